// File: rtl/avr_data_ram.sv
// Parametrised single-port data RAM for the AVR core with a req/ready handshake,
// configurable wait states, out-of-range flagging and an optional zero-fill sweep after reset.
module avr_data_ram #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 2048,
  parameter int WAIT_STATES  = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              stall,
  output logic              busy_init
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {INIT, IDLE, WAIT, DONE} state_t;

  function automatic logic f_oor(input logic [ADDR_W-1:0] a);
    return (33'(a) >= 33'(DEPTH));
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state;
  state_t            w_next;
  logic              r_live;
  logic [IDX_W-1:0]  r_clr_idx;
  logic [3:0]        r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_we;
  logic              r_oor;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ready;
  logic              r_err;
  logic              r_stall;
  logic              r_busy_init;

  logic              w_addr_oor;
  logic              w_cur_oor;
  logic              w_cur_we;
  logic [IDX_W-1:0]  w_cur_idx;
  logic              w_mem_we;
  logic [IDX_W-1:0]  w_mem_idx;
  logic [DATA_W-1:0] w_mem_wd;
  logic              w_enter_done;

  // Next-state logic and the single RAM port steering
  always_comb begin
    w_next       = r_state;
    w_addr_oor   = f_oor(addr);
    w_cur_oor    = r_oor;
    w_cur_we     = r_we;
    w_cur_idx    = r_idx;
    w_mem_we     = 1'b0;
    w_mem_idx    = r_idx;
    w_mem_wd     = wdata;
    w_enter_done = 1'b0;
    case (r_state)
      INIT: begin
        w_mem_idx = r_clr_idx;
        w_mem_wd  = {DATA_W{1'b0}};
        w_mem_we  = r_live;
        if (r_live && (r_clr_idx == IDX_W'(DEPTH - 1))) begin
          w_next = IDLE;
        end else begin
          w_next = INIT;
        end
      end
      IDLE: begin
        // Zero-wait accesses complete straight from the live bus, so route it to the port
        w_cur_oor = w_addr_oor;
        w_cur_we  = we;
        w_cur_idx = addr[IDX_W-1:0];
        w_mem_idx = addr[IDX_W-1:0];
        if (req) begin
          w_mem_we = we && !w_addr_oor;
          w_next   = (WAIT_STATES == 0) ? DONE : WAIT;
        end else begin
          w_next = IDLE;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next = DONE;
        end else begin
          w_next = WAIT;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    w_enter_done = (w_next == DONE);
  end

  // RAM array write port; contents are deliberately not reset
  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_wd;
    end
  end

  // Control state, latched request and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= (CLEAR_ON_RST != 0) ? INIT : IDLE;
      r_live      <= 1'b0;
      r_clr_idx   <= {IDX_W{1'b0}};
      r_cnt       <= 4'd0;
      r_idx       <= {IDX_W{1'b0}};
      r_we        <= 1'b0;
      r_oor       <= 1'b0;
      r_rdata     <= {DATA_W{1'b0}};
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_stall     <= 1'b0;
      r_busy_init <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_live      <= 1'b1;
      r_ready     <= w_enter_done;
      r_err       <= w_enter_done && w_cur_oor;
      r_stall     <= (w_next == WAIT) || (w_next == INIT);
      r_busy_init <= (w_next == INIT);
      if ((r_state == INIT) && r_live) begin
        r_clr_idx <= r_clr_idx + IDX_W'(1);
      end
      if ((r_state == IDLE) && req) begin
        r_idx <= addr[IDX_W-1:0];
        r_we  <= we;
        r_oor <= w_addr_oor;
        r_cnt <= 4'(WAIT_STATES - 1);
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // rdata only moves when a read completes; writes leave it alone
      if (w_enter_done && !w_cur_we) begin
        r_rdata <= w_cur_oor ? {DATA_W{1'b0}} : r_mem[w_cur_idx];
      end
    end
  end

  assign rdata     = r_rdata;
  assign ready     = r_ready;
  assign err       = r_err;
  assign stall     = r_stall;
  assign busy_init = r_busy_init;

endmodule

// File: tb/tb_avr_data_ram.sv
// Directed bench for avr_data_ram: three instances cover zero-wait, wait-state/small-depth
// and no-clear configurations; a vector table plus hand-written reset and streaming sequences.
module tb_avr_data_ram;

  logic       CLK;
  logic       rst   [3];
  logic       req   [3];
  logic       we    [3];
  logic [15:0] addr [3];
  logic [7:0] wdata [3];
  logic [7:0] rdata [3];
  logic       ready [3];
  logic       err   [3];
  logic       stall [3];
  logic       busy  [3];

  int n_tests = 0;
  int n_fail  = 0;
  int ws_of [3] = '{0, 3, 5};

  avr_data_ram #(.ADDR_W(16), .DATA_W(8), .DEPTH(2048), .WAIT_STATES(0), .CLEAR_ON_RST(1)) u0 (
    .CLK(CLK), .RST(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .ready(ready[0]), .err(err[0]), .stall(stall[0]), .busy_init(busy[0]));

  avr_data_ram #(.ADDR_W(16), .DATA_W(8), .DEPTH(16), .WAIT_STATES(3), .CLEAR_ON_RST(1)) u1 (
    .CLK(CLK), .RST(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .ready(ready[1]), .err(err[1]), .stall(stall[1]), .busy_init(busy[1]));

  avr_data_ram #(.ADDR_W(16), .DATA_W(8), .DEPTH(2048), .WAIT_STATES(5), .CLEAR_ON_RST(0)) u2 (
    .CLK(CLK), .RST(rst[2]), .req(req[2]), .we(we[2]), .addr(addr[2]), .wdata(wdata[2]),
    .rdata(rdata[2]), .ready(ready[2]), .err(err[2]), .stall(stall[2]), .busy_init(busy[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         k;
    logic       w;
    logic [15:0] a;
    logic [7:0] d;
    logic [7:0] q;
    logic       e;
  } vec_t;

  vec_t tv [16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic access(input int k, input logic w, input logic [15:0] a, input logic [7:0] d,
                        output int lat, output int stl, output logic [7:0] q, output logic e);
    @(negedge CLK);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    lat = 0; stl = 0;
    do begin
      @(negedge CLK);
      lat++;
      if (stall[k]) stl++;
    end while (!ready[k] && lat < 40);
    q = rdata[k];
    e = err[k];
    req[k] = 1'b0;
  endtask

  initial begin
    int lat, stl, cnt, t, seen;
    logic [7:0] q;
    logic e;
    logic [7:0] bb [3];
    bb = '{8'h10, 8'h20, 8'h30};

    tv[0]  = '{0, 1'b1, 16'h0100, 8'h5C, 8'h00, 1'b0};
    tv[1]  = '{0, 1'b0, 16'h0100, 8'h00, 8'h5C, 1'b0};
    tv[2]  = '{0, 1'b1, 16'h0800, 8'h77, 8'h5C, 1'b1};
    tv[3]  = '{0, 1'b0, 16'h0800, 8'h00, 8'h00, 1'b1};
    tv[4]  = '{0, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0};
    tv[5]  = '{0, 1'b1, 16'h07FF, 8'hFF, 8'h00, 1'b0};
    tv[6]  = '{0, 1'b0, 16'h07FF, 8'h00, 8'hFF, 1'b0};
    tv[7]  = '{0, 1'b1, 16'h0005, 8'h01, 8'hFF, 1'b0};
    tv[8]  = '{0, 1'b0, 16'hFFFF, 8'h00, 8'h00, 1'b1};
    tv[9]  = '{0, 1'b0, 16'h0005, 8'h00, 8'h01, 1'b0};
    tv[10] = '{1, 1'b1, 16'h0007, 8'h3E, 8'h00, 1'b0};
    tv[11] = '{1, 1'b0, 16'h0007, 8'h00, 8'h3E, 1'b0};
    tv[12] = '{1, 1'b0, 16'h0017, 8'h00, 8'h00, 1'b1};
    tv[13] = '{1, 1'b1, 16'h0010, 8'h99, 8'h00, 1'b1};
    tv[14] = '{1, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0};
    tv[15] = '{1, 1'b0, 16'h0007, 8'h00, 8'h3E, 1'b0};

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0; addr[k] = 16'h0000; wdata[k] = 8'h00;
    end
    repeat (3) @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      chk("rst_rdata", 32'(rdata[k]), 32'h0);
      chk("rst_ready", 32'(ready[k]), 32'h0);
      chk("rst_stall", 32'(stall[k]), 32'h0);
    end
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    @(negedge CLK);
    chk("init_busy_starts", 32'(busy[0]), 32'h1);
    t = 0;
    while ((busy[0] || busy[1]) && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    chk("init_sweep_timeout", 32'(t < 3000), 32'h1);

    for (int i = 0; i < 16; i++) begin
      access(tv[i].k, tv[i].w, tv[i].a, tv[i].d, lat, stl, q, e);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(ws_of[tv[i].k] + 1));
      chk($sformatf("vec%0d_stall_cycles", i), 32'(stl), 32'(ws_of[tv[i].k]));
      chk($sformatf("vec%0d_rdata", i), 32'(q), 32'(tv[i].q));
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(tv[i].e));
      @(negedge CLK);
      chk($sformatf("vec%0d_ready_one_cycle", i), 32'(ready[tv[i].k]), 32'h0);
    end

    // Reset/sweep on the 16-deep instance: preload, reset, count busy cycles, read back zero
    access(1, 1'b1, 16'h0003, 8'hAA, lat, stl, q, e);
    access(1, 1'b0, 16'h0003, 8'h00, lat, stl, q, e);
    chk("preload_read", 32'(q), 32'hAA);
    #2;
    rst[1] = 1'b0;
    #1;
    chk("async_rst_rdata", 32'(rdata[1]), 32'h0);
    chk("async_rst_ready", 32'(ready[1]), 32'h0);
    chk("async_rst_busy", 32'(busy[1]), 32'h0);
    repeat (2) @(negedge CLK);
    rst[1] = 1'b1;
    cnt = 0;
    @(negedge CLK);
    while (busy[1] && cnt < 100) begin
      chk("sweep_stall", 32'(stall[1]), 32'h1);
      cnt++;
      @(negedge CLK);
    end
    chk("sweep_busy_cycles", 32'(cnt), 32'd16);
    access(1, 1'b0, 16'h0003, 8'h00, lat, stl, q, e);
    chk("sweep_cleared", 32'(q), 32'h00);

    // Back-to-back with req held: write/read alternation on 0x0042
    @(negedge CLK);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0042; wdata[0] = bb[0];
    for (int i = 0; i < 6; i++) begin
      lat = 0;
      do begin
        @(negedge CLK);
        lat++;
      end while (!ready[0] && lat < 20);
      chk($sformatf("b2b%0d_spacing", i), 32'(lat), (i == 0) ? 32'd1 : 32'd2);
      if (i % 2 == 1) begin
        chk($sformatf("b2b%0d_rdata", i), 32'(rdata[0]), 32'(bb[i / 2]));
        we[0] = 1'b1;
        if (i < 5) wdata[0] = bb[(i + 1) / 2];
      end else begin
        we[0] = 1'b0;
      end
    end
    req[0] = 1'b0;

    // Reset dropped between edges two cycles into a 5-wait-state write
    @(negedge CLK);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h0020; wdata[2] = 8'h11;
    @(posedge CLK);
    @(posedge CLK);
    @(posedge CLK);
    #2;
    chk("midacc_stall_before", 32'(stall[2]), 32'h1);
    rst[2] = 1'b0;
    #1;
    chk("midacc_stall_cleared", 32'(stall[2]), 32'h0);
    chk("midacc_ready_cleared", 32'(ready[2]), 32'h0);
    req[2] = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge CLK);
      if (ready[2]) seen++;
    end
    rst[2] = 1'b1;
    repeat (8) begin
      @(negedge CLK);
      if (ready[2]) seen++;
    end
    chk("midacc_no_ready", 32'(seen), 32'h0);
    access(2, 1'b0, 16'h0020, 8'h00, lat, stl, q, e);
    chk("midacc_write_kept", 32'(q), 32'h11);
    chk("midacc_read_latency", 32'(lat), 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
